// File: rtl/halt_dump_monitor.sv
// halt_dump_monitor: watches the retiring PC of the single-cycle core, detects
// end of program (PC match, PC stall, cycle timeout) and then streams every
// architectural register out over a valid/ready channel via the core's
// reg_sel/reg_data debug port.
// Optional feature macro DUMP_PC_EN: appends one beat carrying the halt PC
// (dump_idx = NREG) after the last register.
module halt_dump_monitor #(
   parameter int              XLEN        = 32,
   parameter int              NREG        = 32,
   parameter logic [XLEN-1:0] HALT_PC     = 32'h0000_0310,
   parameter int              STALL_LIMIT = 3,
   parameter int              TIMEOUT     = 1000,
   localparam int             IW          = $clog2(NREG) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic            pc_valid,
   output logic [IW-2:0]   reg_sel,
   input  logic [XLEN-1:0] reg_data,
   output logic            dump_valid,
   input  logic            dump_ready,
   output logic [IW-1:0]   dump_idx,
   output logic [XLEN-1:0] dump_data,
   output logic            halted,
   output logic [1:0]      halt_cause,
   output logic [31:0]     cycle_cnt,
   output logic            done
);

   typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_SHOW, ST_DONE} state_t;

   localparam logic [IW-1:0] LAST_REG     = IW'(NREG - 1);
`ifdef DUMP_PC_EN
   localparam logic [IW-1:0] LAST_BEAT    = IW'(NREG);
`else
   localparam logic [IW-1:0] LAST_BEAT    = LAST_REG;
`endif
   localparam logic [31:0]   STALL_LIM    = 32'(STALL_LIMIT);
   localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [XLEN-1:0] last_pc_q, last_pc_d;
   logic            seen_q, seen_d;
   logic [31:0]     stall_cnt_q, stall_cnt_d;
   logic [31:0]     cycle_cnt_q, cycle_cnt_d;
   logic            halted_q, halted_d;
   logic [1:0]      cause_q, cause_d;
   logic            done_q, done_d;
   logic [IW-1:0]   dump_idx_q, dump_idx_d;
   logic [XLEN-1:0] dump_data_q, dump_data_d;

   logic hit_pc, hit_repeat, hit_stall, hit_timeout;

   // Halt trigger conditions; only acted upon while in RUN
   always_comb begin
      hit_pc      = pc_valid && (pc == HALT_PC);
      hit_repeat  = pc_valid && seen_q && (pc == last_pc_q);
      hit_stall   = hit_repeat && ((stall_cnt_q + 32'd1) >= STALL_LIM);
      hit_timeout = (cycle_cnt_q == TIMEOUT_LAST);
   end

   // Next-state logic: halt detection in RUN, then LOAD/SHOW per dumped beat
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_pc_d   = last_pc_q;
      seen_d      = seen_q;
      stall_cnt_d = stall_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      halted_d    = halted_q;
      cause_d     = cause_q;
      done_d      = done_q;
      dump_idx_d  = dump_idx_q;
      dump_data_d = dump_data_q;
      unique case (state_q)
         ST_RUN: begin
            if (pc_valid) begin
               last_pc_d   = pc;
               seen_d      = 1'b1;
               stall_cnt_d = hit_repeat ? (stall_cnt_q + 32'd1) : 32'd0;
            end
            if (hit_pc || hit_stall || hit_timeout) begin
               // cycle_cnt freezes on the trigger edge
               halted_d = 1'b1;
               if (hit_pc)         cause_d = 2'b01;
               else if (hit_stall) cause_d = 2'b10;
               else                cause_d = 2'b11;
               idx_d   = '0;
               state_d = ST_LOAD;
            end else if (cycle_cnt_q != 32'hFFFF_FFFF) begin
               cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
         end
         ST_LOAD: begin
            dump_idx_d = idx_q;
            // x0 is hardwired zero; never trust the port for it
            if (idx_q == '0) begin
               dump_data_d = '0;
`ifdef DUMP_PC_EN
            end else if (idx_q == LAST_BEAT) begin
               dump_data_d = last_pc_q;
`endif
            end else begin
               dump_data_d = reg_data;
            end
            state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (dump_ready) begin
               if (idx_q == LAST_BEAT) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ST_LOAD;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Debug-port select follows the beat index; the PC beat keeps the last register selected
   always_comb begin
      reg_sel = idx_q[IW-2:0];
      if (idx_q > LAST_REG) reg_sel = LAST_REG[IW-2:0];
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         idx_q       <= '0;
         last_pc_q   <= '0;
         seen_q      <= 1'b0;
         stall_cnt_q <= '0;
         cycle_cnt_q <= '0;
         halted_q    <= 1'b0;
         cause_q     <= 2'b00;
         done_q      <= 1'b0;
         dump_idx_q  <= '0;
         dump_data_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_pc_q   <= last_pc_d;
         seen_q      <= seen_d;
         stall_cnt_q <= stall_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         halted_q    <= halted_d;
         cause_q     <= cause_d;
         done_q      <= done_d;
         dump_idx_q  <= dump_idx_d;
         dump_data_q <= dump_data_d;
      end
   end

   assign dump_valid = (state_q == ST_SHOW);
   assign dump_idx   = dump_idx_q;
   assign dump_data  = dump_data_q;
   assign halted     = halted_q;
   assign halt_cause = cause_q;
   assign cycle_cnt  = cycle_cnt_q;
   assign done       = done_q;

endmodule

// File: tb/tb_halt_dump_monitor.sv
// tb_halt_dump_monitor: randomized episodes (run until halt, then dump) checked
// against a reference model built on the history of valid PCs.
// Define DUMP_PC_EN for both bench and RTL to exercise the halt-PC beat.
module tb_halt_dump_monitor;
   localparam int          XLEN        = 32;
   localparam int          NREG        = 32;
   localparam int          STALL_LIMIT = 3;
   localparam int          TIMEOUT     = 400;
   localparam logic [31:0] HALT_PC     = 32'h0000_0310;
   localparam int          IW          = $clog2(NREG) + 1;
`ifdef DUMP_PC_EN
   localparam int          NBEATS      = NREG + 1;
`else
   localparam int          NBEATS      = NREG;
`endif

   logic            clk;
   logic            rst;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic [IW-2:0]   reg_sel;
   logic [XLEN-1:0] reg_data;
   logic            dump_valid;
   logic            dump_ready;
   logic [IW-1:0]   dump_idx;
   logic [XLEN-1:0] dump_data;
   logic            halted;
   logic [1:0]      halt_cause;
   logic [31:0]     cycle_cnt;
   logic            done;

   logic [XLEN-1:0] regs [NREG];
   int n_checks = 0;
   int n_errors = 0;

   assign reg_data = regs[reg_sel];

   halt_dump_monitor #(
      .XLEN(XLEN), .NREG(NREG), .HALT_PC(HALT_PC),
      .STALL_LIMIT(STALL_LIMIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid),
      .reg_sel(reg_sel), .reg_data(reg_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_data(dump_data),
      .halted(halted), .halt_cause(halt_cause),
      .cycle_cnt(cycle_cnt), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_halted"},     64'(halted),     64'd0);
      chk({tag, "_cause"},      64'(halt_cause), 64'd0);
      chk({tag, "_cycle_cnt"},  64'(cycle_cnt),  64'd0);
      chk({tag, "_done"},       64'(done),       64'd0);
      chk({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
      chk({tag, "_dump_idx"},   64'(dump_idx),   64'd0);
      chk({tag, "_dump_data"},  64'(dump_data),  64'd0);
      chk({tag, "_reg_sel"},    64'(reg_sel),    64'd0);
   endtask

   // Asynchronous reset pulse starting mid-cycle; returns on a falling edge
   task automatic do_reset();
      #2;
      rst        = 1'b1;
      pc_valid   = 1'b0;
      dump_ready = 1'b0;
      #1;
      check_idle("rst_async");
      @(posedge clk);
      #1;
      check_idle("rst_hold");
      @(negedge clk);
      rst = 1'b0;
   endtask

   // kind: 0 ramp always valid, 1 stall at 0x40, 2 no valid pc (timeout),
   //       3 HALT_PC on the timeout cycle, 4 stall limit on the timeout cycle,
   //       5 ramp with gaps, 6 random small pc set
   // rmode: 0 ready always, 1 ready one cycle in three, 2 random ready
   task automatic run_episode(input int kind, input int rmode, input bit ramp_regs,
                              input int abort_step, input int abort_beat);
      logic [31:0] vpcs[$];
      logic [31:0] exp_data[$];
      logic [31:0] ramp, p, hpc, hdata, r;
      logic [IW-1:0] hidx;
      logic v, rdy, held;
      int n, cause, reps, beats, c, sel_exp;

      do_reset();
      for (int i = 0; i < NREG; i++) regs[i] = ramp_regs ? 32'(i) * 32'h11 : $urandom;
      ramp  = 32'd0;
      n     = 0;
      cause = 0;
      while (cause == 0) begin
         if (n == abort_step) begin
            do_reset();
            return;
         end
         r = $urandom;
         case (kind)
            0: begin v = 1'b1; p = ramp; end
            1: begin v = 1'b1; p = (n < 5) ? 32'h1000 + 32'(n) * 4 : 32'h40; end
            2: begin v = 1'b0; p = r; end
            3: begin v = (n == TIMEOUT - 1); p = v ? HALT_PC : r; end
            4: begin v = (n >= TIMEOUT - 1 - STALL_LIMIT); p = v ? 32'h80 : r; end
            5: begin v = (r[1:0] != 2'b00); p = v ? ramp : $urandom; end
            default: begin
               v = r[4];
               p = (r[3:0] == 4'd0) ? HALT_PC : 32'h40 + 32'(r[3:0] % 4'd3) * 4;
            end
         endcase
         if (v) ramp = ramp + 32'd4;
         pc_valid = v;
         pc       = p;
         // reference: repeats = run of identical valid pcs immediately before this one
         reps = 0;
         if (v) begin
            for (int j = vpcs.size() - 1; j >= 0; j--) begin
               if (vpcs[j] != p) break;
               reps++;
            end
            vpcs.push_back(p);
         end
         if (v && p == HALT_PC)                cause = 1;
         else if (v && reps >= STALL_LIMIT)    cause = 2;
         else if (n == TIMEOUT - 1)            cause = 3;
         @(negedge clk);
         if (cause == 0) begin
            chk("run_halted", 64'(halted),    64'd0);
            chk("run_cnt",    64'(cycle_cnt), 64'(n + 1));
         end
         n++;
      end
      n--;
      hpc = (vpcs.size() > 0) ? vpcs[vpcs.size() - 1] : 32'd0;
      chk("trig_halted", 64'(halted),     64'd1);
      chk("trig_cause",  64'(halt_cause), 64'(cause));
      chk("trig_cnt",    64'(cycle_cnt),  64'(n));
      chk("trig_load",   64'(dump_valid), 64'd0);

      for (int i = 0; i < NREG; i++) exp_data.push_back(i == 0 ? 32'd0 : regs[i]);
`ifdef DUMP_PC_EN
      exp_data.push_back(hpc);
`endif

      beats    = 0;
      held     = 1'b0;
      hidx     = '0;
      hdata    = '0;
      pc_valid = 1'($urandom_range(1));
      pc       = $urandom;
      @(negedge clk);
      c = 1;
      chk("first_beat_latency", 64'(dump_valid), 64'd1);
      while (beats < NBEATS && c < 40 * NBEATS) begin
         chk("dump_not_done", 64'(done), 64'd0);
         if (held) begin
            chk("hold_valid", 64'(dump_valid), 64'd1);
            chk("hold_idx",   64'(dump_idx),   64'(hidx));
            chk("hold_data",  64'(dump_data),  64'(hdata));
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (c % 3 == 0);
            default: rdy = 1'($urandom_range(1));
         endcase
         if (dump_valid) begin
            if (beats == abort_beat) begin
               do_reset();
               return;
            end
            sel_exp = (beats < NREG) ? beats : NREG - 1;
            chk("reg_sel", 64'(reg_sel), 64'(sel_exp));
            if (rdy) begin
               chk("beat_idx",  64'(dump_idx),  64'(beats));
               chk("beat_data", 64'(dump_data), 64'(exp_data[beats]));
               beats++;
               held = 1'b0;
            end else begin
               held  = 1'b1;
               hidx  = dump_idx;
               hdata = dump_data;
            end
         end else begin
            held = 1'b0;
         end
         dump_ready = rdy;
         pc_valid   = 1'($urandom_range(1));
         pc         = $urandom_range(1) ? HALT_PC : $urandom;
         @(negedge clk);
         c++;
      end
      chk("dump_beats", 64'(beats), 64'(NBEATS));
      chk("done_set",   64'(done),       64'd1);
      chk("done_valid", 64'(dump_valid), 64'd0);
      if (rmode == 0) chk("done_latency", 64'(c), 64'(2 * NBEATS));

      for (int k = 0; k < 4; k++) begin
         dump_ready = 1'($urandom_range(1));
         pc_valid   = 1'b1;
         pc         = (k == 0) ? HALT_PC : $urandom;
         @(negedge clk);
      end
      chk("hold_done",    64'(done),       64'd1);
      chk("hold_halted",  64'(halted),     64'd1);
      chk("hold_cause",   64'(halt_cause), 64'(cause));
      chk("hold_cnt",     64'(cycle_cnt),  64'(n));
      chk("hold_novalid", 64'(dump_valid), 64'd0);
   endtask

   initial begin
      rst        = 1'b0;
      pc         = '0;
      pc_valid   = 1'b0;
      dump_ready = 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] = '0;

      run_episode(0, 0, 1'b1, -1, -1);
      run_episode(1, 1, 1'b0, -1, -1);
      run_episode(2, 2, 1'b0, -1, -1);
      run_episode(3, 0, 1'b0, -1, -1);
      run_episode(4, 1, 1'b0, -1, -1);
      run_episode(5, 2, 1'b0, 60, -1);
      run_episode(1, 2, 1'b0, -1, 5);
      for (int e = 0; e < 8; e++) begin
         run_episode((e % 2 == 1) ? 6 : 5, int'($urandom_range(2)), 1'b0, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
